// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Samples an asynchronous PWM line, measures its period and high time in
//   clk cycles and quantises the duty cycle to a decile level 0..10. The
//   level is shown on an 8-bit seven-segment code that matches the PWM
//   generator's switch display.
//
// Parameters
//   DATA   generator counter width (nominal period is 2**DATA cycles)
//   CNT_W  width of the period/high counters; the timeout is 2**CNT_W-1 cycles
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   pwm_in     asynchronous PWM input line
//   level      measured duty decile, 0..10
//   seg_out    seven-segment code for level (10 shows only the decimal point)
//   valid      one-cycle pulse when level/period/high_time update
//   period     last captured period in clk cycles (0 after a timeout)
//   high_time  last captured high time in clk cycles (0 after a timeout)
//
// Optional feature
//   PWM_DEGLITCH_EN  when defined, the synchronised input only changes after
//                    three consecutive equal samples, rejecting pulses shorter
//                    than 3 clk; this adds 2 clk of latency.
//
// States
//   WAIT_EDGE | counters idle, waiting for the first rising edge
//   RUN       | counting; each rising edge captures a period and starts a calc
//   TIMEOUT   | no edge for 2**CNT_W-1 cycles; report a flat 0% or 100% line

module pwm_duty_meter #(
    parameter int DATA  = 8,
    parameter int CNT_W = DATA + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [3:0]       level,
    output logic [7:0]       seg_out,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time
);

    localparam int CALC_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        RUN       = 2'd1,
        TIMEOUT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic sync1, s_in;
    logic sig, sig_d, rise;

    logic [CNT_W-1:0]  per_cnt, hi_cnt;
    logic              calc_busy;
    logic [3:0]        calc_cnt;
    logic [3:0]        lvl_acc;
    logic [CALC_W-1:0] thr;
    logic [CALC_W-1:0] per_ext, hi_ext, hi20;
    logic              calc_done, capture, do_timeout;

    function automatic logic [7:0] seg_decode(input logic [3:0] lv);
        case (lv)
            4'd0:    return 8'b1111_1100;
            4'd1:    return 8'b0110_0000;
            4'd2:    return 8'b1101_1010;
            4'd3:    return 8'b1111_0010;
            4'd4:    return 8'b0110_0110;
            4'd5:    return 8'b1011_0110;
            4'd6:    return 8'b1011_1110;
            4'd7:    return 8'b1110_0000;
            4'd8:    return 8'b1111_1110;
            4'd9:    return 8'b1110_0110;
            4'd10:   return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            s_in  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            s_in  <= sync1;
        end
    end

`ifdef PWM_DEGLITCH_EN
    logic h1, h2, filt;

    // The filtered value follows s_in as soon as the current sample and the
    // two before it agree, so a clean edge costs exactly two extra cycles.
    always_comb begin
        sig = filt;
        if ((s_in == h1) && (h1 == h2)) begin
            sig = s_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1   <= 1'b0;
            h2   <= 1'b0;
            filt <= 1'b0;
        end else begin
            h1   <= s_in;
            h2   <= h1;
            filt <= sig;
        end
    end

    assign sig_d = filt;
`else
    assign sig = s_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end
`endif

    assign rise = sig & ~sig_d;

    assign calc_done  = calc_busy && (calc_cnt == 4'd10);
    assign capture    = (state == RUN) && rise;
    // A calc finishing in the TIMEOUT cycle is reported first; the timeout
    // itself is then handled one cycle later.
    assign do_timeout = (state == TIMEOUT) && !calc_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_EDGE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_EDGE: if (rise) state_nxt = RUN;
            RUN:       if (!rise && (per_cnt == CNT_MAX)) state_nxt = TIMEOUT;
            TIMEOUT:   if (!calc_done) state_nxt = WAIT_EDGE;
            default:   state_nxt = WAIT_EDGE;
        endcase
    end

    // The edge cycle itself is high, so both counters restart at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise && (state != TIMEOUT)) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else if (state == RUN) begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
            if (sig && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_W'(1);
        end else if (do_timeout) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end
    end

    // level = #{k in 1..10 : 20*high >= (2k-1)*period}, one k per cycle.
    assign per_ext = CALC_W'(period);
    assign hi_ext  = CALC_W'(high_time);
    assign hi20    = (hi_ext << 4) + (hi_ext << 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level     <= 4'd0;
            seg_out   <= 8'b1111_1100;
            valid     <= 1'b0;
            period    <= '0;
            high_time <= '0;
            calc_busy <= 1'b0;
            calc_cnt  <= 4'd0;
            lvl_acc   <= 4'd0;
            thr       <= '0;
        end else begin
            valid <= 1'b0;
            if (capture) begin
                // A new edge always wins: any calc in flight is dropped.
                period    <= per_cnt;
                high_time <= hi_cnt;
                thr       <= CALC_W'(per_cnt);
                lvl_acc   <= 4'd0;
                calc_cnt  <= 4'd0;
                calc_busy <= 1'b1;
            end else if (calc_done) begin
                level     <= lvl_acc;
                seg_out   <= seg_decode(lvl_acc);
                valid     <= 1'b1;
                calc_busy <= 1'b0;
            end else if (do_timeout) begin
                level     <= sig ? 4'd10 : 4'd0;
                seg_out   <= seg_decode(sig ? 4'd10 : 4'd0);
                valid     <= 1'b1;
                period    <= '0;
                high_time <= '0;
                calc_busy <= 1'b0;
            end else if (calc_busy) begin
                if (hi20 >= thr) lvl_acc <= lvl_acc + 4'd1;
                thr      <= thr + (per_ext << 1);
                calc_cnt <= calc_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter. Waveforms are built as per-cycle sample arrays;
// a reference model derives the expected valid pulses from the rising edges
// of the (optionally deglitched) waveform, and every valid (expected or
// actual) is compared cycle by cycle.
module tb_pwm_duty_meter;

    localparam int DATA  = 8;
    localparam int CNT_W = 10;
    localparam int MAXC  = 4200;
`ifdef PWM_DEGLITCH_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 14;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_in = 1'b0;
    logic [3:0]       level;
    logic [7:0]       seg_out;
    logic             valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    pwm_duty_meter #(.DATA(DATA), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .level(level),
        .seg_out(seg_out), .valid(valid), .period(period), .high_time(high_time)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] seg_tab [11];

    bit  wave [MAXC];
    int  wlen;
    bit  ev_v   [MAXC+32];
    int  ev_lvl [MAXC+32];
    int  ev_per [MAXC+32];
    int  ev_hi  [MAXC+32];
    int  ev_count;

    int  nvalid, first_idx, last_idx, n_off5;
    int  last_lvl, last_seg, last_per, last_hi;
    string cur_tag;

    typedef struct {
        int         p;
        int         h;
        int         lvl;
        logic [7:0] seg;
    } vec_t;
    vec_t tab [13];

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s [%s]: got %0d, want %0d", name, cur_tag, got, want);
        end
    endtask

    task automatic clear_wave();
        wlen = 0;
    endtask

    task automatic add(input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            wave[wlen] = b;
            wlen++;
        end
    endtask

    task automatic add_period(input int p, input int h);
        add(1'b1, h);
        add(1'b0, p - h);
    endtask

    function automatic int duty_level(input int p, input int h);
        int n = 0;
        for (int k = 1; k <= 10; k++) begin
            if (20 * h >= (2 * k - 1) * p) n++;
        end
        return n;
    endfunction

    task automatic add_event(input int idx, input int lv, input int p, input int h);
        if (idx <= wlen) begin
            ev_v[idx]   = 1'b1;
            ev_lvl[idx] = lv;
            ev_per[idx] = p;
            ev_hi[idx]  = h;
            ev_count++;
        end
    endtask

    // Sample x[n] is driven just after posedge n; a rising edge at sample r
    // yields its result just after posedge r+14 (latency already absorbed by
    // the filter in the deglitch build). A line silent for more than 1023
    // samples after an edge at a reports at a+1027 using sample a+1024, and
    // edges before a+1025 are not seen.
    task automatic build_model();
        bit e [MAXC];
        int rises[$];
        int arm, blocked, r, p, h;
        for (int n = 0; n < wlen; n++) begin
`ifdef PWM_DEGLITCH_EN
            bit a, b, c, pf;
            a  = wave[n];
            b  = (n >= 1) ? wave[n-1] : 1'b0;
            c  = (n >= 2) ? wave[n-2] : 1'b0;
            pf = (n >= 1) ? e[n-1] : 1'b0;
            e[n] = (a == b && b == c) ? a : pf;
`else
            e[n] = wave[n];
`endif
        end
        for (int n = 0; n < wlen; n++) begin
            if (e[n] && !((n >= 1) ? e[n-1] : 1'b0)) rises.push_back(n);
        end
        for (int i = 0; i < MAXC + 32; i++) ev_v[i] = 1'b0;
        ev_count = 0;
        arm = -1;
        blocked = 0;
        for (int i = 0; i < rises.size(); i++) begin
            r = rises[i];
            if (arm >= 0 && r > arm + 1023) begin
                add_event(arm + 1027, e[arm+1024] ? 10 : 0, 0, 0);
                blocked = arm + 1025;
                arm = -1;
            end
            if (arm < 0) begin
                if (r >= blocked) arm = r;
            end else begin
                p = r - arm;
                h = 0;
                for (int j = arm; j < r; j++) h += e[j];
                if (!(i + 1 < rises.size() && rises[i+1] <= r + 11))
                    add_event(r + 14, duty_level(p, h), p, h);
                arm = r;
            end
        end
        if (arm >= 0 && arm + 1024 < wlen)
            add_event(arm + 1027, e[arm+1024] ? 10 : 0, 0, 0);
    endtask

    task automatic check_cycle(input int m);
        if (valid) begin
            nvalid++;
            if (first_idx < 0) first_idx = m;
            last_idx = m;
            last_lvl = level;
            last_seg = seg_out;
            last_per = period;
            last_hi  = high_time;
            if (level != 4'd5) n_off5++;
        end
        if (valid || ev_v[m]) begin
            total++;
            if (valid !== ev_v[m] ||
                (ev_v[m] && (level !== 4'(ev_lvl[m]) || seg_out !== seg_tab[ev_lvl[m]] ||
                             period !== CNT_W'(ev_per[m]) || high_time !== CNT_W'(ev_hi[m])))) begin
                bad++;
                $display("FAIL model_check [%s] cyc %0d: got v=%0b lvl=%0d seg=%08b per=%0d hi=%0d, want v=%0b lvl=%0d seg=%08b per=%0d hi=%0d",
                         cur_tag, m, valid, level, seg_out, period, high_time,
                         ev_v[m], ev_lvl[m], ev_v[m] ? seg_tab[ev_lvl[m]] : 8'h00, ev_per[m], ev_hi[m]);
            end
        end
    endtask

    // Starts just after a posedge; runs ncyc samples of the current wave.
    task automatic run_wave(input int ncyc);
        nvalid = 0;
        first_idx = -1;
        last_idx = -1;
        n_off5 = 0;
        for (int n = 0; n < ncyc; n++) begin
            pwm_in = wave[n];
            @(posedge clk);
            #1;
            check_cycle(n + 1);
        end
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_reset_vals(input string pre);
        chk({pre, "_level"},  level,     0);
        chk({pre, "_seg"},    seg_out,   8'b1111_1100);
        chk({pre, "_valid"},  valid,     0);
        chk({pre, "_period"}, period,    0);
        chk({pre, "_high"},   high_time, 0);
    endtask

    initial begin
        seg_tab[0] = 8'b1111_1100; seg_tab[1] = 8'b0110_0000; seg_tab[2] = 8'b1101_1010;
        seg_tab[3] = 8'b1111_0010; seg_tab[4] = 8'b0110_0110; seg_tab[5] = 8'b1011_0110;
        seg_tab[6] = 8'b1011_1110; seg_tab[7] = 8'b1110_0000; seg_tab[8] = 8'b1111_1110;
        seg_tab[9] = 8'b1110_0110; seg_tab[10] = 8'b0000_0001;

        tab[0]  = '{256,  26,  1, 8'b0110_0000};
        tab[1]  = '{256, 128,  5, 8'b1011_0110};
        tab[2]  = '{256, 230,  9, 8'b1110_0110};
        tab[3]  = '{256, 255, 10, 8'b0000_0001};
        tab[4]  = '{100,   5,  1, 8'b0110_0000};
        tab[5]  = '{100,   4,  0, 8'b1111_1100};
        tab[6]  = '{100,  15,  2, 8'b1101_1010};
        tab[7]  = '{300,  90,  3, 8'b1111_0010};
        tab[8]  = '{100,  40,  4, 8'b0110_0110};
        tab[9]  = '{100,  60,  6, 8'b1011_1110};
        tab[10] = '{150, 105,  7, 8'b1110_0000};
        tab[11] = '{100,  80,  8, 8'b1111_1110};
        tab[12] = '{ 64,  61, 10, 8'b0000_0001};

        // Reset state
        cur_tag = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b1;

        // Steady waveforms, three periods each
        for (int t = 0; t < 13; t++) begin
            cur_tag = $sformatf("table%0d", t);
            do_reset();
            clear_wave();
            for (int k = 0; k < 3; k++) add_period(tab[t].p, tab[t].h);
            add(1'b0, 40);
            build_model();
            run_wave(wlen);
            chk("tab_count",   nvalid,    2);
            chk("tab_latency", first_idx, tab[t].p + LAT);
            chk("tab_level",   last_lvl,  tab[t].lvl);
            chk("tab_seg",     last_seg,  tab[t].seg);
            chk("tab_period",  last_per,  tab[t].p);
            chk("tab_high",    last_hi,   tab[t].h);
        end

        // Duty change from 50% to 90%
        cur_tag = "switch";
        do_reset();
        clear_wave();
        for (int k = 0; k < 3; k++) add_period(256, 128);
        for (int k = 0; k < 2; k++) add_period(256, 230);
        add(1'b0, 40);
        build_model();
        run_wave(wlen);
        chk("switch_count", nvalid,   4);
        chk("switch_level", last_lvl, 9);
        chk("switch_seg",   last_seg, 8'b1110_0110);

        // Timeout with the line held low, then re-arm on two fresh edges
        cur_tag = "timeout_low";
        do_reset();
        clear_wave();
        add(1'b1, 5);
        add(1'b0, 1100);
        for (int k = 0; k < 2; k++) add_period(100, 30);
        add(1'b0, 40);
        build_model();
        run_wave(1105);
        chk("tmo_lo_count",  nvalid,    1);
        chk("tmo_lo_when",   first_idx, 1027 + LAT - 14);
        chk("tmo_lo_level",  last_lvl,  0);
        chk("tmo_lo_seg",    last_seg,  8'b1111_1100);
        chk("tmo_lo_period", last_per,  0);
        do_reset();
        run_wave(wlen);
        chk("rearm_count", nvalid,   2);
        chk("rearm_level", last_lvl, 3);

        // Timeout with the line held high
        cur_tag = "timeout_high";
        do_reset();
        clear_wave();
        add(1'b1, 1100);
        build_model();
        run_wave(wlen);
        chk("tmo_hi_count",  nvalid,   1);
        chk("tmo_hi_level",  last_lvl, 10);
        chk("tmo_hi_seg",    last_seg, 8'b0000_0001);
        chk("tmo_hi_high",   last_hi,  0);

        // Two edges 6 clk apart: first calc abandoned
        cur_tag = "abort";
        do_reset();
        clear_wave();
        add(1'b1, 150); add(1'b0, 150);
        add(1'b1, 3);   add(1'b0, 3);
        add(1'b1, 3);   add(1'b0, 60);
        build_model();
        run_wave(wlen);
        chk("abort_count",  nvalid,   1);
        chk("abort_period", last_per, 6);
        chk("abort_high",   last_hi,  3);
        chk("abort_level",  last_lvl, 5);

        // Reset mid-calc
        cur_tag = "midreset";
        do_reset();
        clear_wave();
        for (int k = 0; k < 2; k++) add_period(100, 50);
        add(1'b0, 40);
        build_model();
        run_wave(106);
        chk("mid_period_before", period, 100);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("mid");
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_wave();
        for (int k = 0; k < 3; k++) add_period(100, 50);
        add(1'b0, 40);
        build_model();
        run_wave(wlen);
        chk("mid_first_valid", first_idx, 100 + LAT);
        chk("mid_count",       nvalid,    2);

        // Short glitches inside a 50% waveform
        cur_tag = "glitch";
        do_reset();
        clear_wave();
        add_period(256, 128);
        add(1'b1, 128); add(1'b0, 52); add(1'b1, 1); add(1'b0, 75);
        add(1'b1, 128); add(1'b0, 72); add(1'b1, 2); add(1'b0, 54);
        add_period(256, 128);
        add_period(256, 128);
        add(1'b0, 40);
        build_model();
        run_wave(wlen);
`ifdef PWM_DEGLITCH_EN
        chk("glitch_off5", n_off5, 0);
        chk("glitch_count", nvalid, 4);
`else
        chk("glitch_recapture", (n_off5 > 0) ? 1 : 0, 1);
`endif

        // Randomized waveforms against the model
        for (int rnd = 0; rnd < 8; rnd++) begin
            int p, h, np;
            cur_tag = $sformatf("random%0d", rnd);
            do_reset();
            clear_wave();
            np = (rnd == 7) ? 3 : 6;
            for (int k = 0; k < np; k++) begin
                p = (rnd == 7) ? int'($urandom_range(1000, 1050)) : int'($urandom_range(16, 400));
                h = int'($urandom_range(1, p - 1));
                add_period(p, h);
            end
            add(1'b0, 40);
            build_model();
            run_wave(wlen);
            chk("rand_count", nvalid, ev_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
